// File: rtl/line_scheduler.sv
// Frame-boundary reload sequencer for a bank of line engines: double-buffered
// endpoint tables, atomic commit at the boundary, staggered engine reloads.
module line_scheduler #(
  parameter int ENGINES  = 4,
  parameter int V_ACTIVE = 480,
  parameter int IW       = (ENGINES > 1) ? $clog2(ENGINES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [9:0]              x,
  input  logic [9:0]              y,
  input  logic                    wr_en,
  input  logic [IW-1:0]           wr_idx,
  input  logic [9:0]              wr_x1,
  input  logic [9:0]              wr_y1,
  input  logic [9:0]              wr_x2,
  input  logic [9:0]              wr_y2,
  input  logic                    wr_ena,
  input  logic                    commit,
  output logic                    commit_pending,
  output logic                    busy,
  output logic                    frame_tick,
  output logic [ENGINES-1:0]      eng_rst,
  output logic [10*ENGINES-1:0]   eng_x1,
  output logic [10*ENGINES-1:0]   eng_y1,
  output logic [10*ENGINES-1:0]   eng_x2,
  output logic [10*ENGINES-1:0]   eng_y2,
  input  logic [ENGINES-1:0]      eng_white,
  output logic                    white
);

  typedef enum logic [1:0] {IDLE, COPY, LOAD} state_t;

  localparam logic [IW:0]   NUM_SLOTS = (IW+1)'(ENGINES);
  localparam logic [IW-1:0] LAST_IDX  = IW'(ENGINES - 1);

  state_t          state_reg;
  logic [IW-1:0]   index_reg;
  logic            pending_reg;
  logic            tick_reg;
  logic            at_b_q;

  logic [9:0]         sh_x1 [ENGINES];
  logic [9:0]         sh_y1 [ENGINES];
  logic [9:0]         sh_x2 [ENGINES];
  logic [9:0]         sh_y2 [ENGINES];
  logic [ENGINES-1:0] sh_ena;
  logic [9:0]         act_x1 [ENGINES];
  logic [9:0]         act_y1 [ENGINES];
  logic [9:0]         act_x2 [ENGINES];
  logic [9:0]         act_y2 [ENGINES];
  logic [ENGINES-1:0] act_ena;

  logic at_b;
  logic tick_cond;
  logic wr_ok;

  // The beam parks on the boundary pixel for several clocks; only its first
  // clock counts as the frame boundary.
  assign at_b      = (x == 10'd0) && (y == 10'(V_ACTIVE));
  assign tick_cond = at_b & ~at_b_q;
  assign wr_ok     = wr_en && ({1'b0, wr_idx} < NUM_SLOTS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      index_reg   <= '0;
      pending_reg <= 1'b0;
      tick_reg    <= 1'b0;
      at_b_q      <= 1'b0;
      sh_ena      <= '0;
      act_ena     <= '0;
      for (int i = 0; i < ENGINES; i++) begin
        sh_x1[i]  <= '0;
        sh_y1[i]  <= '0;
        sh_x2[i]  <= '0;
        sh_y2[i]  <= '0;
        act_x1[i] <= '0;
        act_y1[i] <= '0;
        act_x2[i] <= '0;
        act_y2[i] <= '0;
      end
    end else begin
      at_b_q   <= at_b;
      tick_reg <= tick_cond && (state_reg == IDLE);

      if (wr_ok) begin
        sh_x1[wr_idx]  <= wr_x1;
        sh_y1[wr_idx]  <= wr_y1;
        sh_x2[wr_idx]  <= wr_x2;
        sh_y2[wr_idx]  <= wr_y2;
        sh_ena[wr_idx] <= wr_ena;
      end

      case (state_reg)
        IDLE: begin
          if (tick_cond) state_reg <= COPY;
        end
        COPY: begin
          // Copy reads the pre-edge shadow, so a same-cycle write waits for
          // the next commit.
          if (pending_reg) begin
            for (int i = 0; i < ENGINES; i++) begin
              act_x1[i] <= sh_x1[i];
              act_y1[i] <= sh_y1[i];
              act_x2[i] <= sh_x2[i];
              act_y2[i] <= sh_y2[i];
            end
            act_ena     <= sh_ena;
            pending_reg <= 1'b0;
          end
          index_reg <= '0;
          state_reg <= LOAD;
        end
        LOAD: begin
          index_reg <= index_reg + 1'b1;
          if (index_reg == LAST_IDX) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase

      // A fresh commit wins over the clear performed by COPY.
      if (commit) pending_reg <= 1'b1;
    end
  end

  always_comb begin
    eng_rst = '0;
    if (rst) begin
      eng_rst = '1;
    end else if (state_reg == LOAD) begin
      eng_rst[index_reg] = 1'b1;
    end
  end

  assign commit_pending = pending_reg;
  assign busy           = (state_reg != IDLE);
  assign frame_tick     = tick_reg;
  assign white          = |(eng_white & act_ena);

  generate
    for (genvar gi = 0; gi < ENGINES; gi++) begin : g_pack
      assign eng_x1[10*gi +: 10] = act_x1[gi];
      assign eng_y1[10*gi +: 10] = act_y1[gi];
      assign eng_x2[10*gi +: 10] = act_x2[gi];
      assign eng_y2[10*gi +: 10] = act_y2[gi];
    end
  endgenerate

endmodule
